// File: rtl/bg_mosaic_hold.sv
// -----------------------------------------------------------------------------
// bg_mosaic_hold
//
// Per-BG mosaic sample-and-hold stage. It sits between the BG fetch/decode
// outputs and the priority/colour-math mixer and adds one dot of latency.
// When the mosaic controller flags the first dot of a horizontal mosaic block
// (pixel_strobe), or when the active display period starts (period_start),
// every layer's pixel word is captured. Layers with mosaic in effect then
// replay the captured word for the rest of the block. Other layers pass
// straight through, one dot late.
//
// Mosaic configuration (size, per-layer enable, optional hi-res) is shadowed
// at the start of each scanline. Writes made in the middle of a line only
// take effect at the next newline.
//
// Optional feature: define MOSAIC_HIRES_EN to add the hi-res sub-pixel path
// (ports hires, pix_sub_in, pix_sub_out). In a hi-res line, a layer with
// mosaic in effect shows the left (sub) half-dot sample on both outputs.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   dot_en         dot clock enable; no state changes while low
//   newline        start of scanline (qualified by dot_en)
//   period_start   start of active display on this line (forces a capture)
//   pixel_strobe   first dot of a horizontal mosaic block
//   cfg_size       mosaic size register (block width = cfg_size+1 dots)
//   cfg_enable     per-layer mosaic enable bits (bit i = BG i+1)
//   pix_in         unmosaiced pixels, layer i at [i*PIX_W +: PIX_W]
//   pix_out        mosaiced pixels, same packing, registered
//   mosaic_active  per-layer effective mosaic state, changes only at newline
//   hires          (MOSAIC_HIRES_EN) hi-res mode, shadowed at newline
//   pix_sub_in     (MOSAIC_HIRES_EN) left half-dot pixels, same packing
//   pix_sub_out    (MOSAIC_HIRES_EN) mosaiced sub pixels, registered
// -----------------------------------------------------------------------------
module bg_mosaic_hold #(
  parameter int NUM_BG = 4,
  parameter int PIX_W  = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    dot_en,
  input  logic                    newline,
  input  logic                    period_start,
  input  logic                    pixel_strobe,
  input  logic [3:0]              cfg_size,
  input  logic [NUM_BG-1:0]       cfg_enable,
  input  logic [NUM_BG*PIX_W-1:0] pix_in,
`ifdef MOSAIC_HIRES_EN
  input  logic                    hires,
  input  logic [NUM_BG*PIX_W-1:0] pix_sub_in,
  output logic [NUM_BG*PIX_W-1:0] pix_sub_out,
`endif
  output logic [NUM_BG*PIX_W-1:0] pix_out,
  output logic [NUM_BG-1:0]       mosaic_active
);

  typedef logic [NUM_BG-1:0][PIX_W-1:0] pix_vec_t;

  // Shadowed configuration.
  logic [3:0]        size_q, size_d;
  logic [NUM_BG-1:0] en_q, en_d;

  // Per-layer hold registers and the output register.
  pix_vec_t hold_q, hold_d;
  pix_vec_t pix_out_q, pix_out_d;

  pix_vec_t pix_in_a;
  logic [NUM_BG-1:0] act;
  logic capture;

  assign pix_in_a = pix_in;
  assign capture  = period_start | pixel_strobe;

  // A mosaic size of 0 means 1-dot blocks. That is the same as no mosaic.
  // act is derived only from the shadow registers, so it can change only
  // at newline or reset.
  assign act = en_q & {NUM_BG{size_q != 4'd0}};

`ifdef MOSAIC_HIRES_EN
  logic     hires_q, hires_d;
  pix_vec_t hold_sub_q, hold_sub_d;
  pix_vec_t pix_sub_out_q, pix_sub_out_d;
  pix_vec_t pix_sub_in_a;

  assign pix_sub_in_a = pix_sub_in;
  assign pix_sub_out  = pix_sub_out_q;
`endif

  // Next-state logic. On a newline dot, act still holds the OLD
  // configuration. A capture on that dot therefore uses the pre-latch state,
  // and the new configuration applies from the following dot.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    size_d    = size_q;
    en_d      = en_q;
    hold_d    = hold_q;
    pix_out_d = pix_out_q;
`ifdef MOSAIC_HIRES_EN
    hires_d       = hires_q;
    hold_sub_d    = hold_sub_q;
    pix_sub_out_d = pix_sub_out_q;
`endif
    if (dot_en) begin
      if (newline) begin
        size_d = cfg_size;
        en_d   = cfg_enable;
`ifdef MOSAIC_HIRES_EN
        hires_d = hires;
`endif
      end
      for (int i = 0; i < NUM_BG; i++) begin
        // Hold registers capture on every capture dot, whether or not the
        // layer is active. A layer that gets enabled at newline therefore
        // always has a valid sample.
        if (capture) begin
          hold_d[i] = pix_in_a[i];
        end
        pix_out_d[i] = (act[i] && !capture) ? hold_q[i] : pix_in_a[i];
`ifdef MOSAIC_HIRES_EN
        if (capture) begin
          hold_sub_d[i] = pix_sub_in_a[i];
        end
        if (hires_q && act[i]) begin
          // Hi-res mosaic: the left half-dot sample fills the whole block.
          pix_out_d[i]     = capture ? pix_sub_in_a[i] : hold_sub_q[i];
          pix_sub_out_d[i] = capture ? pix_sub_in_a[i] : hold_sub_q[i];
        end else begin
          pix_sub_out_d[i] = pix_sub_in_a[i];
        end
`endif
      end
    end
  end

  // The hold registers are reset along with everything else. After a
  // mid-line reset, a replayed value is then a defined 0 rather than stale
  // data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q    <= '0;
      en_q      <= '0;
      hold_q    <= '0;
      pix_out_q <= '0;
`ifdef MOSAIC_HIRES_EN
      hires_q       <= 1'b0;
      hold_sub_q    <= '0;
      pix_sub_out_q <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      size_q    <= size_d;
      en_q      <= en_d;
      hold_q    <= hold_d;
      pix_out_q <= pix_out_d;
`ifdef MOSAIC_HIRES_EN
      hires_q       <= hires_d;
      hold_sub_q    <= hold_sub_d;
      pix_sub_out_q <= pix_sub_out_d;
`endif
    end
  end

  assign pix_out       = pix_out_q;
  assign mosaic_active = act;

endmodule

// File: tb/tb_bg_mosaic_hold.sv
// -----------------------------------------------------------------------------
// Directed testbench for bg_mosaic_hold (NUM_BG=4, PIX_W=12).
// Inputs change 1 time unit after each rising edge. Outputs are sampled at
// the same point, so nothing is sampled on the active clock edge.
// -----------------------------------------------------------------------------
module tb_bg_mosaic_hold;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              dot_en;
  logic              newline;
  logic              period_start;
  logic              pixel_strobe;
  logic [3:0]        cfg_size;
  logic [3:0]        cfg_enable;
  logic [3:0][11:0]  pin;
  logic [3:0][11:0]  pout;
  logic [3:0]        mact;
`ifdef MOSAIC_HIRES_EN
  logic              hires;
  logic [3:0][11:0]  psub_in;
  logic [3:0][11:0]  psub_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bg_mosaic_hold #(.NUM_BG(4), .PIX_W(12)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dot_en       (dot_en),
    .newline      (newline),
    .period_start (period_start),
    .pixel_strobe (pixel_strobe),
    .cfg_size     (cfg_size),
    .cfg_enable   (cfg_enable),
    .pix_in       (pin),
`ifdef MOSAIC_HIRES_EN
    .hires        (hires),
    .pix_sub_in   (psub_in),
    .pix_sub_out  (psub_out),
`endif
    .pix_out      (pout),
    .mosaic_active(mact)
  );

  // Presents one dot with the given controls, then returns 1 unit after the edge.
  task automatic dot(input logic en, input logic nl, input logic ps, input logic st);
    dot_en       = en;
    newline      = nl;
    period_start = ps;
    pixel_strobe = st;
    @(posedge clk);
    #1;
    dot_en       = 1'b0;
    newline      = 1'b0;
    period_start = 1'b0;
    pixel_strobe = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (pout !== '0) begin
      errors++;
      $display("FAIL reset_pout got=%h exp=0", pout);
    end
    checks++;
    if (mact !== 4'h0) begin
      errors++;
      $display("FAIL reset_mact got=%h exp=0", mact);
    end
  endtask

  // size=0 means no mosaic: every layer is a plain 1-dot delay.
  task automatic test_passthrough();
    cfg_size   = 4'd0;
    cfg_enable = 4'hF;
    pin        = '0;
    dot(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      pin[0] = 12'(k);
      dot(1'b1, 1'b0, 1'b0, (k % 2) == 0);
      checks++;
      if (pout[0] !== 12'(k)) begin
        errors++;
        $display("FAIL pass_ramp k=%0d got=%h exp=%h", k, pout[0], 12'(k));
      end
      checks++;
      if (mact !== 4'h0) begin
        errors++;
        $display("FAIL pass_mact k=%0d got=%h exp=0", k, mact);
      end
    end
  endtask

  // size=3, BG1 only. period_start forces the first capture, then a strobe
  // arrives every 4th dot.
  task automatic test_hold();
    logic [11:0] exp_v;
    cfg_size   = 4'd3;
    cfg_enable = 4'b0001;
    pin        = '0;
    dot(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 4; j++) pin[j] = 12'(k + 256 * j);
      dot(1'b1, 1'b0, k == 0, (k != 0) && (k % 4 == 0));
      exp_v = 12'((k / 4) * 4);
      checks++;
      if (pout[0] !== exp_v) begin
        errors++;
        $display("FAIL hold_bg1 k=%0d got=%h exp=%h", k, pout[0], exp_v);
      end
      for (int j = 1; j < 4; j++) begin
        checks++;
        if (pout[j] !== 12'(k + 256 * j)) begin
          errors++;
          $display("FAIL hold_pass bg%0d k=%0d got=%h exp=%h", j + 1, k, pout[j], 12'(k + 256 * j));
        end
      end
      checks++;
      if (mact !== 4'b0001) begin
        errors++;
        $display("FAIL hold_mact k=%0d got=%h exp=1", k, mact);
      end
    end
  endtask

  // A mid-line cfg_enable write is ignored until newline. The newline dot
  // itself still uses the old state.
  task automatic test_cfg_midline();
    logic [11:0] exp_tab [5];
    cfg_enable = 4'b0000;
    exp_tab = '{12'd12, 12'd12, 12'd12, 12'd12, 12'd16};
    for (int k = 12; k <= 16; k++) begin
      pin[0] = 12'(k);
      // k=15 is the newline dot without a capture. k=16 is after the newline.
      dot(1'b1, k == 15, 1'b0, k == 12);
      checks++;
      if (pout[0] !== exp_tab[k - 12]) begin
        errors++;
        $display("FAIL midline k=%0d got=%h exp=%h", k, pout[0], exp_tab[k - 12]);
      end
      checks++;
      if (mact !== ((k >= 15) ? 4'b0000 : 4'b0001)) begin
        errors++;
        $display("FAIL midline_mact k=%0d got=%h", k, mact);
      end
    end
    // Newline together with a capture that turns mosaic on. The capture dot
    // passes through, and the next dot replays the captured value.
    cfg_enable = 4'b0001;
    cfg_size   = 4'd3;
    pin[0]     = 12'h055;
    dot(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (pout[0] !== 12'h055) begin
      errors++;
      $display("FAIL nl_capture got=%h exp=055", pout[0]);
    end
    pin[0] = 12'h066;
    dot(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pout[0] !== 12'h055) begin
      errors++;
      $display("FAIL nl_capture_hold got=%h exp=055", pout[0]);
    end
    checks++;
    if (mact !== 4'b0001) begin
      errors++;
      $display("FAIL nl_capture_mact got=%h exp=1", mact);
    end
  endtask

  // With dot_en low, every input is ignored and no state changes.
  task automatic test_dot_en_freeze();
    pin        = {4{12'h777}};
    cfg_enable = 4'b0000;
    cfg_size   = 4'd0;
    for (int c = 0; c < 5; c++) begin
      dot(1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (pout[0] !== 12'h055 || mact !== 4'b0001) begin
        errors++;
        $display("FAIL freeze c=%0d got=%h/%h exp=055/1", c, pout[0], mact);
      end
    end
    cfg_enable = 4'b0001;
    cfg_size   = 4'd3;
    pin[0]     = 12'h099;
    dot(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pout[0] !== 12'h055) begin
      errors++;
      $display("FAIL freeze_resume got=%h exp=055", pout[0]);
    end
    pin[0] = 12'h0A0;
    dot(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (pout[0] !== 12'h0A0) begin
      errors++;
      $display("FAIL freeze_recapture got=%h exp=0a0", pout[0]);
    end
  endtask

`ifdef MOSAIC_HIRES_EN
  task automatic test_hires();
    hires      = 1'b1;
    cfg_size   = 4'd1;
    cfg_enable = 4'b0001;
    dot(1'b1, 1'b1, 1'b0, 1'b0);
    psub_in[0] = 12'd10; pin[0] = 12'd11;
    psub_in[1] = 12'h021; pin[1] = 12'h031;
    dot(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (pout[0] !== 12'd10 || psub_out[0] !== 12'd10) begin
      errors++;
      $display("FAIL hires_strobe got=%0d/%0d exp=10/10", pout[0], psub_out[0]);
    end
    checks++;
    if (psub_out[1] !== 12'h021 || pout[1] !== 12'h031) begin
      errors++;
      $display("FAIL hires_inactive got=%h/%h exp=021/031", psub_out[1], pout[1]);
    end
    psub_in[0] = 12'd12; pin[0] = 12'd13;
    dot(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pout[0] !== 12'd10 || psub_out[0] !== 12'd10) begin
      errors++;
      $display("FAIL hires_hold got=%0d/%0d exp=10/10", pout[0], psub_out[0]);
    end
    hires = 1'b0;
  endtask
`endif

  // An asynchronous reset in the middle of the stream clears outputs at once.
  task automatic test_reset_midline();
    pin = {4{12'hABC}};
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (pout !== '0 || mact !== 4'h0) begin
      errors++;
      $display("FAIL rst_async got=%h/%h exp=0/0", pout, mact);
    end
    dot(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (pout !== '0) begin
      errors++;
      $display("FAIL rst_held got=%h exp=0", pout);
    end
    reset_n = 1'b1;
    pin = {4{12'hABC}};
    dot(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pout !== '0) begin
      errors++;
      $display("FAIL rst_release_idle got=%h exp=0", pout);
    end
    pin = {4{12'hABC}};
    dot(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pout !== {4{12'hABC}} || mact !== 4'h0) begin
      errors++;
      $display("FAIL rst_first_dot got=%h/%h exp=abcabcabcabc/0", pout, mact);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    dot_en       = 1'b0;
    newline      = 1'b0;
    period_start = 1'b0;
    pixel_strobe = 1'b0;
    cfg_size     = 4'd0;
    cfg_enable   = 4'h0;
    pin          = '0;
`ifdef MOSAIC_HIRES_EN
    hires        = 1'b0;
    psub_in      = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    test_passthrough();
    test_hold();
    test_cfg_midline();
    test_dot_en_freeze();
`ifdef MOSAIC_HIRES_EN
    test_hires();
`endif
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
